// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg
//   Shared definitions for the ALU scheduler slice: the scheduler FSM state
//   encoding, the ALU opcode values and the bit positions inside resp_flags.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int FLG_ZERO = 0;
  localparam int FLG_OVF  = 1;
  localparam int FLG_DBZ  = 2;
  localparam int FLG_TMO  = 3;

endpackage

// File: rtl/alu_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational rotating-priority arbiter. Searches req_valid upward from
//   rr_ptr (wrapping modulo NREQ) and grants the first valid requester.
// Ports:
//   req_valid  in   NREQ          requests
//   rr_ptr     in   $clog2(NREQ)  highest-priority index this cycle
//   grant      out  NREQ          one-hot grant, zero when nothing is valid
//   grant_idx  out  $clog2(NREQ)  index of the granted requester
//   any        out  1             at least one request is valid
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_valid,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  // One extra bit so rr_ptr + k never wraps before the explicit modulo.
  logic [IW:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) begin
        idx = idx - (IW+1)'(NREQ);
      end
      if (!any && req_valid[idx[IW-1:0]]) begin
        any              = 1'b1;
        grant_idx        = idx[IW-1:0];
        grant[idx[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Shares one multi-cycle ALU between NREQ requesters. One operation is in
//   flight at a time: IDLE arbitrates and latches operands, ISSUE pulses
//   alu_start, WAIT waits for alu_done under a watchdog, RESP presents the
//   tagged result until it is accepted.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. The producer holds valid and its payload stable until
//   that edge; ready may depend combinationally on valid (req_ready does),
//   valid never depends on ready.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                per-requester request handshake
//   req_a, req_b, req_op               packed per-requester operands/opcode
//   resp_valid/resp_ready              response handshake
//   resp_id, resp_result, resp_flags   owner, 2N-bit result, {tmo,dbz,ovf,zero}
//   alu_start, alu_a, alu_b, alu_opcode  command side of the shared ALU
//   alu_result, alu_done, alu_overflow, alu_div_by_zero, alu_zero  ALU status
//   dbg_state                          current FSM state
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*N-1:0]       req_a,
  input  logic [NREQ*N-1:0]       req_b,
  input  logic [NREQ*2-1:0]       req_op,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [2*N-1:0]          resp_result,
  output logic [3:0]              resp_flags,
  output logic                    alu_start,
  output logic [N-1:0]            alu_a,
  output logic [N-1:0]            alu_b,
  output logic [1:0]              alu_opcode,
  input  logic [2*N-1:0]          alu_result,
  input  logic                    alu_done,
  input  logic                    alu_overflow,
  input  logic                    alu_div_by_zero,
  input  logic                    alu_zero,
  output sched_state_t            dbg_state
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam int DW = $clog2(2*TIMEOUT);

  sched_state_t    state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [WW-1:0]   wd_cnt;
  logic            drain;
  logic [DW-1:0]   drain_cnt;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            any;
  logic            accept;
  logic            alu_fin;
  logic            wd_expire;
  logic [3:0]      alu_flags;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // While draining after a timeout the ALU may still be busy with the
  // aborted operation, so no new request is accepted.
  assign accept    = (state == ST_IDLE) && !drain && any;
  assign alu_fin   = (state == ST_WAIT) && alu_done;
  assign wd_expire = (state == ST_WAIT) && !alu_done && (wd_cnt == WW'(TIMEOUT-1));
  assign dbg_state = state;

  always_comb begin
    alu_flags           = '0;
    alu_flags[FLG_ZERO] = alu_zero;
    alu_flags[FLG_OVF]  = alu_overflow;
    alu_flags[FLG_DBZ]  = alu_div_by_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    alu_start  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          req_ready = grant;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_done || wd_expire) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
      wd_cnt      <= '0;
      drain       <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      if (accept) begin
        alu_a      <= req_a[grant_idx*N +: N];
        alu_b      <= req_b[grant_idx*N +: N];
        alu_opcode <= req_op[grant_idx*2 +: 2];
        resp_id    <= grant_idx;
        rr_ptr     <= (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end

      if (state == ST_ISSUE)     wd_cnt <= '0;
      else if (state == ST_WAIT) wd_cnt <= wd_cnt + 1'b1;

      if (alu_fin) begin
        resp_result <= alu_result;
        resp_flags  <= alu_flags;
      end else if (wd_expire) begin
        resp_result          <= '0;
        resp_flags           <= '0;
        resp_flags[FLG_TMO]  <= 1'b1;
      end

      // Drain ends on the aborted operation's late done, or after
      // 2*TIMEOUT cycles if that done never shows up.
      if (wd_expire) begin
        drain     <= 1'b1;
        drain_cnt <= '0;
      end else if (drain) begin
        if (alu_done || drain_cnt == DW'(2*TIMEOUT-1)) drain <= 1'b0;
        drain_cnt <= drain_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
`timescale 1ns/1ps
module tb_alu_scheduler;
  import alu_sched_pkg::*;

  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [NREQ*2-1:0] req_op;
  logic              resp_valid, resp_ready;
  logic [1:0]        resp_id;
  logic [2*N-1:0]    resp_result;
  logic [3:0]        resp_flags;
  logic              alu_start;
  logic [N-1:0]      alu_a, alu_b;
  logic [1:0]        alu_opcode;
  logic [2*N-1:0]    alu_result;
  logic              alu_done, alu_overflow, alu_div_by_zero, alu_zero;
  sched_state_t      dbg_state;

  int checks = 0;
  int fails  = 0;
  logic [21:0] exp_q[$];

  alu_scheduler #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_flags(resp_flags),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_done(alu_done), .alu_overflow(alu_overflow),
    .alu_div_by_zero(alu_div_by_zero), .alu_zero(alu_zero),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- reference ALU behaviour ----------------
  // Returns {flags[3:0], result[15:0]} with flags = {tmo, dbz, ovf, zero}.
  function automatic logic [19:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    int   ai, bi, r;
    logic ovf, dbz;
    ai = int'(a); bi = int'(b); r = 0; ovf = 1'b0; dbz = 1'b0;
    case (op)
      OP_ADD: begin r = ai + bi; ovf = (r > 255); r = r % 256; end
      OP_SUB: begin ovf = (ai < bi); r = (ai - bi + 256) % 256; end
      OP_MUL: begin r = ai * bi; ovf = (r > 255); end
      default: begin
        if (bi == 0) dbz = 1'b1;
        else         r = ai / bi;
      end
    endcase
    return {1'b0, dbz, ovf, (r == 0), r[15:0]};
  endfunction

  // ALU stub: done three cycles after start (six for divide), optional hang,
  // and an injectable stray done carrying a junk result.
  bit alu_hang   = 1'b0;
  int inject_req = 0;
  int inject_seen = 0;

  initial begin
    int          cnt;
    bit          busy;
    logic [7:0]  sa, sb;
    logic [1:0]  sop;
    logic [19:0] r;
    busy = 1'b0; cnt = 0; sa = '0; sb = '0; sop = '0; r = '0;
    alu_done = 1'b0; alu_result = '0;
    alu_overflow = 1'b0; alu_div_by_zero = 1'b0; alu_zero = 1'b0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 1'b0;
            if (!alu_hang) begin
              r = ref_alu(sa, sb, sop);
              alu_result = r[15:0]; alu_zero = r[16];
              alu_overflow = r[17]; alu_div_by_zero = r[18];
              alu_done = 1'b1;
            end
          end
        end
        if (inject_req != inject_seen) begin
          inject_seen = inject_req;
          alu_result = 16'hdead; alu_zero = 1'b0;
          alu_overflow = 1'b1; alu_div_by_zero = 1'b1;
          alu_done = 1'b1;
        end
        if (alu_start) begin
          busy = 1'b1;
          cnt  = (alu_opcode == OP_DIV) ? 6 : 3;
          sa = alu_a; sb = alu_b; sop = alu_opcode;
        end
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    req_op[id*2 +: 2] = op;
    req_valid[id] = 1'b1;
  endtask

  // Called in cycle 1 (right after the request handshake edge).
  task automatic finish_txn(input string tag, input int id, input logic [7:0] a,
                            input logic [7:0] b, input logic [1:0] op,
                            input logic [15:0] e_res, input logic [3:0] e_flg,
                            input int e_lat);
    int lat;
    check({tag, "_alu_start"}, alu_start, 1);
    check({tag, "_alu_ops"}, {alu_opcode, alu_a, alu_b}, {op, a, b});
    lat = 1;
    while (!resp_valid && lat < 400) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_resp"}, {resp_valid, resp_id, resp_flags, resp_result},
          {1'b1, 2'(id), e_flg, e_res});
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_resp_done"}, resp_valid, 0);
  endtask

  task automatic single_txn(input string tag, input int id, input logic [7:0] a,
                            input logic [7:0] b, input logic [1:0] op,
                            input logic [15:0] e_res, input logic [3:0] e_flg,
                            input int e_lat);
    drive_req(id, a, b, op);
    #1;
    check({tag, "_req_ready"}, req_ready, 1 << id);
    tick();
    req_valid = '0;
    finish_txn(tag, id, a, b, op, e_res, e_flg, e_lat);
  endtask

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    int   n, win, lat, dly;
    bit   leak;
    logic [3:0]  mask;
    logic [7:0]  ra[NREQ], rb[NREQ];
    logic [1:0]  rop[NREQ];
    logic [21:0] exp_v;
    int   rr_model;

    tbl[0] = '{2, 8'd200, 8'd100, OP_ADD, 16'd44,    4'b0010, 5};
    tbl[1] = '{1, 8'd9,   8'd0,   OP_DIV, 16'd0,     4'b0101, 8};
    tbl[2] = '{0, 8'd15,  8'd17,  OP_MUL, 16'd255,   4'b0000, 5};
    tbl[3] = '{3, 8'd10,  8'd10,  OP_SUB, 16'd0,     4'b0001, 5};
    tbl[4] = '{1, 8'd5,   8'd7,   OP_SUB, 16'd254,   4'b0010, 5};
    tbl[5] = '{0, 8'd100, 8'd7,   OP_DIV, 16'd14,    4'b0000, 8};
    tbl[6] = '{3, 8'd255, 8'd255, OP_MUL, 16'd65025, 4'b0010, 5};
    tbl[7] = '{2, 8'd0,   8'd0,   OP_ADD, 16'd0,     4'b0001, 5};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b0;
    repeat (2) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_resp", {resp_valid, resp_id, resp_flags, resp_result}, 0);
    check("rst_alu", {alu_start, alu_opcode, alu_a, alu_b}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // Directed vectors, issued back to back.
    for (int i = 0; i < 8; i++) begin
      single_txn($sformatf("tbl%0d", i), tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op,
                 tbl[i].res, tbl[i].flg, tbl[i].lat);
    end

    // All four requesters hold valid: grants rotate 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NREQ; i++) drive_req(i, 8'd15, 8'd17, OP_MUL);
    for (int g = 0; g < 5; g++) begin
      #1;
      check("rr_grant", req_ready, 1 << (g % NREQ));
      tick();
      leak = 1'b0;
      lat  = 1;
      while (!resp_valid && lat < 400) begin
        if (req_ready != '0) leak = 1'b1;
        tick();
        lat++;
      end
      check("rr_ready_low", leak, 0);
      check("rr_latency", lat, 5);
      check("rr_resp", {resp_id, resp_flags, resp_result}, {2'(g % NREQ), 4'b0, 16'd255});
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end
    req_valid = '0;

    // Backpressure: response held 10 cycles while requester 0 waits.
    drive_req(2, 8'd50, 8'd8, OP_SUB);
    #1;
    check("bp_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    drive_req(0, 8'd3, 8'd4, OP_MUL);
    lat = 1;
    while (!resp_valid && lat < 400) begin
      tick();
      lat++;
    end
    check("bp_latency", lat, 5);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold", {req_ready, resp_valid, resp_id, resp_flags, resp_result},
            {4'b0, 1'b1, 2'd2, 4'b0, 16'd42});
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_next_accept", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    finish_txn("bp_second", 0, 8'd3, 8'd4, OP_MUL, 16'd12, 4'b0000, 5);

    // Timeout, then drain released by a stray late done.
    alu_hang = 1'b1;
    single_txn("tmo", 1, 8'd1, 8'd2, OP_ADD, 16'd0, 4'b1000, TIMEOUT + 2);
    alu_hang = 1'b0;
    drive_req(2, 8'd7, 8'd8, OP_ADD);
    #1;
    leak = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (req_ready != '0) leak = 1'b1;
      tick();
    end
    check("tmo_drain_block", leak, 0);
    inject_req++;
    tick();
    check("tmo_drain_release", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    finish_txn("tmo_after", 2, 8'd7, 8'd8, OP_ADD, 16'd15, 4'b0000, 5);

    // Timeout with no late done: drain expires on its own.
    alu_hang = 1'b1;
    single_txn("tmo2", 3, 8'd9, 8'd9, OP_SUB, 16'd0, 4'b1000, TIMEOUT + 2);
    alu_hang = 1'b0;
    drive_req(0, 8'd20, 8'd3, OP_MUL);
    #1;
    n = 0;
    while (!req_ready[0] && n < 4*TIMEOUT) begin
      tick();
      n++;
    end
    checks++;
    if (n < 2*TIMEOUT - 8 || n > 2*TIMEOUT + 2) begin
      fails++;
      $display("FAIL drain_expiry: waited %0d cycles, expected %0d..%0d",
               n, 2*TIMEOUT - 8, 2*TIMEOUT + 2);
    end
    tick();
    req_valid = '0;
    finish_txn("tmo2_after", 0, 8'd20, 8'd3, OP_MUL, 16'd60, 4'b0000, 5);

    // Async reset while waiting on the ALU.
    drive_req(1, 8'd33, 8'd44, OP_MUL);
    #1;
    tick();
    req_valid = '0;
    tick();
    tick();
    check("rstw_in_wait", dbg_state, ST_WAIT);
    #1 rst_n = 1'b0;
    #1;
    check("rstw_req_ready", req_ready, 0);
    check("rstw_resp", {resp_valid, resp_id, resp_flags, resp_result}, 0);
    check("rstw_alu", {alu_start, alu_opcode, alu_a, alu_b}, 0);
    check("rstw_state", dbg_state, ST_IDLE);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NREQ; i++) drive_req(i, 8'(i + 1), 8'd2, OP_ADD);
    #1;
    check("rstw_tie_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    finish_txn("rstw_after", 0, 8'd1, 8'd2, OP_ADD, 16'd3, 4'b0000, 5);

    // Randomised requests against the round-robin and ALU model.
    do_reset();
    rr_model = 0;
    for (int it = 0; it < 40; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        ra[i]  = 8'($urandom_range(0, 255));
        rb[i]  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        rop[i] = 2'($urandom_range(0, 3));
        if (mask[i]) drive_req(i, ra[i], rb[i], rop[i]);
      end
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && mask[(rr_model + k) % NREQ]) win = (rr_model + k) % NREQ;
      end
      #1;
      check("rnd_grant", req_ready, 1 << win);
      exp_q.push_back({2'(win), ref_alu(ra[win], rb[win], rop[win])});
      rr_model = (win + 1) % NREQ;
      tick();
      req_valid = '0;
      lat = 1;
      while (!resp_valid && lat < 400) begin
        tick();
        lat++;
      end
      check("rnd_latency", lat, (rop[win] == OP_DIV) ? 8 : 5);
      dly = $urandom_range(0, 3);
      repeat (dly) tick();
      exp_v = exp_q.pop_front();
      check("rnd_resp", {resp_valid, resp_id, resp_flags, resp_result}, {1'b1, exp_v});
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
